pipe_stage_regs: RTL and testbench

//  Three independent pipeline boundary registers of the 4-stage CPU datapath.
//  - IF/ID: fetched PC and instruction.
//  - ID/EX: decoded control bits, immediate, register operands, rd and PC.
//  - EX/WB: memory and ALU results, adder sum, rd and writeback controls.

---
 rtl/pipe_stage_regs.sv | 94 +++++++++
 tb/tb_pipe_stage_regs.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: IF/ID, ID/EX and EX/WB boundary registers; optional PIPE_FLUSH_EN adds a flush input
module pipe_stage_regs #(
  parameter int DW = 32,
  parameter int RW = 6,
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst,
`ifdef PIPE_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [DW-1:0] if_pc,
  input  logic [DW-1:0] if_inst,
  output logic [DW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
  input  logic [CW-1:0] id_ctrl,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_pc_in,
  output logic [CW-1:0] ex_ctrl,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [RW-1:0] ex_rd,
  output logic [DW-1:0] ex_pc,
  input  logic          ex_mem_to_reg,
  input  logic          ex_reg_wrt,
  input  logic          ex_svpc,
  input  logic [DW-1:0] ex_dm_data,
  input  logic [DW-1:0] ex_alu,
  input  logic [DW-1:0] ex_sum,
  input  logic [RW-1:0] ex_rd_in,
  output logic          wb_mem_to_reg,
  output logic          wb_reg_wrt,
  output logic          wb_svpc,
  output logic [DW-1:0] wb_dm_data,
  output logic [DW-1:0] wb_alu,
  output logic [DW-1:0] wb_sum,
  output logic [RW-1:0] wb_rd
);
  logic kill;
`ifdef PIPE_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif
  // IF/ID: capture fetched pc/inst; a flush turns it into a bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else begin
      id_pc   <= kill ? '0 : if_pc;
      id_inst <= kill ? '0 : if_inst;
    end
  // ID/EX: capture decoded fields; a flush only clears the control bundle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_ctrl    <= '0;
      ex_imm     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_rd      <= '0;
      ex_pc      <= '0;
    end else begin
      ex_ctrl    <= kill ? '0 : id_ctrl;
      ex_imm     <= id_imm;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_rd      <= id_rd;
      ex_pc      <= id_pc_in;
    end
  // EX/WB: capture results and writeback controls every edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_mem_to_reg <= 1'b0;
      wb_reg_wrt    <= 1'b0;
      wb_svpc       <= 1'b0;
      wb_dm_data    <= '0;
      wb_alu        <= '0;
      wb_sum        <= '0;
      wb_rd         <= '0;
    end else begin
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_reg_wrt    <= ex_reg_wrt;
      wb_svpc       <= ex_svpc;
      wb_dm_data    <= ex_dm_data;
      wb_alu        <= ex_alu;
      wb_sum        <= ex_sum;
      wb_rd         <= ex_rd_in;
    end
endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb_pipe_stage_regs: directed checks of the three pipeline boundary registers
module tb_pipe_stage_regs;
  logic clk = 1'b0, rst = 1'b0;
`ifdef PIPE_FLUSH_EN
  logic flush = 1'b0;
`endif
  logic [31:0] if_pc, if_inst, id_pc, id_inst;
  logic [12:0] id_ctrl, ex_ctrl;
  logic [31:0] id_imm, id_rs_data, id_rt_data, id_pc_in;
  logic [5:0]  id_rd, ex_rd, ex_rd_in, wb_rd;
  logic [31:0] ex_imm, ex_rs_data, ex_rt_data, ex_pc;
  logic        ex_mem_to_reg, ex_reg_wrt, ex_svpc;
  logic [31:0] ex_dm_data, ex_alu, ex_sum;
  logic        wb_mem_to_reg, wb_reg_wrt, wb_svpc;
  logic [31:0] wb_dm_data, wb_alu, wb_sum;
  int checks = 0, errors = 0;

  pipe_stage_regs dut (
    .clk(clk), .rst(rst),
`ifdef PIPE_FLUSH_EN
    .flush(flush),
`endif
    .if_pc(if_pc), .if_inst(if_inst), .id_pc(id_pc), .id_inst(id_inst),
    .id_ctrl(id_ctrl), .id_imm(id_imm), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rd(id_rd), .id_pc_in(id_pc_in),
    .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_wrt(ex_reg_wrt), .ex_svpc(ex_svpc),
    .ex_dm_data(ex_dm_data), .ex_alu(ex_alu), .ex_sum(ex_sum), .ex_rd_in(ex_rd_in),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_wrt(wb_reg_wrt), .wb_svpc(wb_svpc),
    .wb_dm_data(wb_dm_data), .wb_alu(wb_alu), .wb_sum(wb_sum), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [31:0] v);
    {if_pc, if_inst, id_imm, id_rs_data, id_rt_data, id_pc_in, ex_dm_data, ex_alu, ex_sum} = {9{v}};
    id_ctrl = v[12:0];
    {id_rd, ex_rd_in} = {2{v[5:0]}};
    {ex_mem_to_reg, ex_reg_wrt, ex_svpc} = {3{v[0]}};
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " id_pc"}, id_pc, 0);
    chk({tag, " id_inst"}, id_inst, 0);
    chk({tag, " ex_ctrl"}, ex_ctrl, 0);
    chk({tag, " ex_imm"}, ex_imm, 0);
    chk({tag, " ex_rs_data"}, ex_rs_data, 0);
    chk({tag, " ex_rt_data"}, ex_rt_data, 0);
    chk({tag, " ex_rd"}, ex_rd, 0);
    chk({tag, " ex_pc"}, ex_pc, 0);
    chk({tag, " wb_ctl"}, {wb_mem_to_reg, wb_reg_wrt, wb_svpc}, 0);
    chk({tag, " wb_dm_data"}, wb_dm_data, 0);
    chk({tag, " wb_alu"}, wb_alu, 0);
    chk({tag, " wb_sum"}, wb_sum, 0);
    chk({tag, " wb_rd"}, wb_rd, 0);
  endtask

  initial begin
    set_all(32'hFFFF_FFFF);
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    tick;
    tick;
    chk_zero("rst_held");
    rst = 1'b0;
    set_all(32'h0);
    if_pc = 32'd1;
    if_inst = 32'h1234_5678;
    #2 chk("no_capture_before_edge", id_pc, 0);
    tick;
    chk("ifid_pc", id_pc, 32'd1);
    chk("ifid_inst", id_inst, 32'h1234_5678);
    if_pc = 32'd9;
    if_inst = 32'hDEAD_BEEF;
    #3;
    chk("ifid_pc_stable", id_pc, 32'd1);
    chk("ifid_inst_stable", id_inst, 32'h1234_5678);
    tick;
    chk("ifid_pc_next", id_pc, 32'd9);
    chk("ifid_inst_next", id_inst, 32'hDEAD_BEEF);
    id_ctrl = 13'h1FFF;
    id_imm = 32'hFFFF_FFF0;
    id_rd = 6'h3F;
    id_rs_data = 32'hA5A5_0001;
    id_rt_data = 32'h5A5A_0002;
    id_pc_in = 32'h0000_0400;
    tick;
    chk("idex_ctrl", ex_ctrl, 13'h1FFF);
    chk("idex_imm", ex_imm, 32'hFFFF_FFF0);
    chk("idex_rd", ex_rd, 6'd63);
    chk("idex_rs", ex_rs_data, 32'hA5A5_0001);
    chk("idex_rt", ex_rt_data, 32'h5A5A_0002);
    chk("idex_pc", ex_pc, 32'h0000_0400);
    chk("exwb_idle", wb_alu, 0);
    ex_alu = 32'hA;
    ex_sum = 32'hB;
    ex_dm_data = 32'hC;
    ex_svpc = 1'b1;
    ex_rd_in = 6'd5;
    id_ctrl = 13'h0041;
    tick;
    chk("exwb_alu", wb_alu, 32'hA);
    chk("exwb_sum", wb_sum, 32'hB);
    chk("exwb_dm", wb_dm_data, 32'hC);
    chk("exwb_ctl", {wb_mem_to_reg, wb_reg_wrt, wb_svpc}, 3'b001);
    chk("exwb_rd", wb_rd, 6'd5);
    chk("idex_ctrl2", ex_ctrl, 13'h0041);
    ex_mem_to_reg = 1'b1;
    ex_reg_wrt = 1'b1;
    ex_svpc = 1'b0;
    tick;
    chk("exwb_ctl2", {wb_mem_to_reg, wb_reg_wrt, wb_svpc}, 3'b110);
    for (int i = 0; i < 4; i++) begin
      if_pc = i;
      tick;
      chk($sformatf("stream_%0d", i), id_pc, i);
    end
    if_pc = 32'd4;
    #2 rst = 1'b1;
    #1 chk_zero("mid_rst");
    tick;
    chk("mid_rst_held", id_pc, 0);
    rst = 1'b0;
    #2 chk("rst_release_no_edge", id_pc, 0);
    tick;
    chk("resume_pc", id_pc, 32'd4);
`ifdef PIPE_FLUSH_EN
    flush = 1'b1;
    id_ctrl = 13'h1FFF;
    id_imm = 32'd7;
    if_inst = 32'hCAFE_F00D;
    ex_alu = 32'h77;
    tick;
    chk("flush_ctrl", ex_ctrl, 0);
    chk("flush_imm", ex_imm, 32'd7);
    chk("flush_inst", id_inst, 0);
    chk("flush_pc", id_pc, 0);
    chk("flush_wb", wb_alu, 32'h77);
    flush = 1'b0;
    tick;
    chk("post_flush_ctrl", ex_ctrl, 13'h1FFF);
    chk("post_flush_inst", id_inst, 32'hCAFE_F00D);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
